syn_pcm_mem_mc: RTL
===================

# syn_pcm_mem_mc

Multi-channel, ping-pong PCM sample buffer between the Acortex capture path and the Fgyrus FFT engine. The writer streams per-channel samples into the fill bank; when every channel holds a full frame the banks swap and the frame is offered to the reader via `pcm_data_rdy`. Reads return after a parametrised latency, tagged with address and channel. Overruns are dropped and counted, never corrupt the bank being read.

## Interface
- `DATA_W`, 32: sample width.
- `ADDR_W`, 8: per-channel sample address width; frame depth `DEPTH = 2**ADDR_W`.
- `NUM_CH`, 2: channel count, ≥1.
- `CH_W`, 1: channel index width, `2**CH_W ≥ NUM_CH`.
- `RD_DELAY`, 2: read latency in cycles, ≥1.
- `OVF_CNT_W`, 16: overflow counter width.

Ports:
- `clk_ir` in 1: clock, all logic on rising edge.
- `rst_il` in 1: synchronous, active-high reset.
- `wr_valid` in 1: write strobe.
- `wr_ch` in CH_W: write channel.
- `wr_data` in DATA_W: sample.
- `pcm_data_rdy` out 1: a complete frame is owned by the reader.
- `pcm_rden` in 1: read strobe.
- `pcm_ch` in CH_W: read channel.
- `pcm_addr` in ADDR_W: read sample index.
- `pcm_rd_done` in 1: one-cycle pulse, reader releases the frame.
- `pcm_rdata` out DATA_W: read data.
- `pcm_rd_valid` out 1: `pcm_rdata` valid.
- `pcm_raddr` out ADDR_W: address of returned data.
- `pcm_rch` out CH_W: channel of returned data.
- `ovf_flag` out 1: sticky overflow.
- `ovf_cnt` out OVF_CNT_W: dropped-sample count, saturating.
- `clr_ovf` in 1: clears `ovf_flag` and `ovf_cnt`.

## Operation
- Two banks, each `NUM_CH × DEPTH` words, addressed `{ch, addr}`. Register `wr_bank` selects the fill bank; the read bank is `~wr_bank`.
- Per-channel write pointers `wptr[ch]` (ADDR_W+1 bits). An accepted write stores at `{wr_ch, wptr[wr_ch]}` in the fill bank and increments that pointer.
- A channel is full when `wptr = DEPTH`. The fill bank is complete when all `NUM_CH` channels are full.
- A write is dropped and counted (`ovf_cnt`+1, `ovf_flag`=1) when any of these holds:
  - its channel is full;
  - `wr_ch ≥ NUM_CH`;
  - the fill bank is complete and swap is pending.
- Read FSM, two states:
  - IDLE: `pcm_data_rdy`=0. When the fill bank becomes complete: toggle `wr_bank`, clear all `wptr`, go to RDY.
  - RDY: `pcm_data_rdy`=1. On `pcm_rd_done`:
    - if the fill bank is complete, swap immediately and stay RDY. `pcm_data_rdy` goes low for exactly one cycle, then reasserts.
    - otherwise go to IDLE.
- Reads: `pcm_rden` is honoured only while `pcm_data_rdy`=1; otherwise it is ignored and produces no `pcm_rd_valid`. Data is taken from the bank that was the read bank in the issue cycle. Reads already in the pipeline complete normally across a swap.
- `pcm_rd_done` in IDLE is ignored. `clr_ovf` coinciding with a drop leaves `ovf_cnt`=1 and `ovf_flag`=1; the new drop wins.
- Reset: FSM IDLE, `wr_bank`=0, all `wptr`=0, and all outputs 0 (`pcm_data_rdy`, `pcm_rd_valid`, `pcm_rdata`, `pcm_raddr`, `pcm_rch`, `ovf_flag`, `ovf_cnt`). The read pipeline is flushed. RAM contents are not reset. Reset mid-frame discards the partial frame and any frame held by the reader.

## Timing
- Write to RAM: 1 cycle after `wr_valid`.
- Completion to `pcm_data_rdy`: the write that fills the last channel in cycle N → swap and `pcm_data_rdy`=1 in cycle N+1. A write in cycle N+1 goes to the new fill bank.
- Read latency: `pcm_rden` in cycle N → `pcm_rd_valid`, `pcm_rdata`, `pcm_raddr`, `pcm_rch` in cycle N+RD_DELAY, all aligned. Full throughput, one read per cycle.
- `pcm_rd_done` in cycle N:
  - `pcm_data_rdy`=0 in N+1.
  - If a swap is pending, `pcm_data_rdy`=1 again in N+2.
  - A `pcm_rden` in cycle N is still honoured.
- Completion and `pcm_rd_done` in the same cycle in RDY: treated as a pending swap. `pcm_data_rdy` is low in N+1 and high in N+2.

## Test plan
Bench configuration for all scenarios: NUM_CH=2, ADDR_W=2, RD_DELAY=2.
1. Write ch0 samples 0x10–0x13 and ch1 samples 0x20–0x23, interleaved → `pcm_data_rdy`=1 one cycle after the last write. Reading {ch1, addr 2} returns 0x22, with `pcm_raddr`=2 and `pcm_rch`=1, two cycles later.
2. Back-to-back reads of all 8 addresses → 8 consecutive `pcm_rd_valid` cycles in order, correct data, no gaps.
3. Second frame completes while the reader holds the first; then 3 extra writes arrive → `ovf_cnt`=3, `ovf_flag`=1. After `pcm_rd_done`, `pcm_data_rdy` is low for 1 cycle, then high, and the second frame reads back intact.
4. `pcm_rden` while `pcm_data_rdy`=0, `wr_ch`=3, and a 5th write to a full ch0 → no `pcm_rd_valid`, `ovf_cnt`=2, and bank data unchanged.
5. Assert `rst_il` after 3 writes, then write a full frame → the frame contains only post-reset data; `ovf_cnt`=0; `pcm_data_rdy` asserts after exactly 8 writes.
6. `pcm_rd_done` in the same cycle as a `pcm_rden` and a frame completion → the read returns old-bank data; `pcm_data_rdy` pattern is 0 then 1; the new frame is readable.

Source files
------------

// File: rtl/syn_pcm_mem_mc.sv
// rtl/syn_pcm_mem_mc.sv - ping-pong multi-channel PCM frame buffer with tagged pipelined reads
module syn_pcm_mem_mc #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NUM_CH    = 2,
    parameter int CH_W      = 1,
    parameter int RD_DELAY  = 2,
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk_ir,
    input  logic                 rst_il,
    input  logic                 wr_valid,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 pcm_data_rdy,
    input  logic                 pcm_rden,
    input  logic [CH_W-1:0]      pcm_ch,
    input  logic [ADDR_W-1:0]    pcm_addr,
    input  logic                 pcm_rd_done,
    output logic [DATA_W-1:0]    pcm_rdata,
    output logic                 pcm_rd_valid,
    output logic [ADDR_W-1:0]    pcm_raddr,
    output logic [CH_W-1:0]      pcm_rch,
    output logic                 ovf_flag,
    output logic [OVF_CNT_W-1:0] ovf_cnt,
    input  logic                 clr_ovf
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int MEM_AW = 1 + CH_W + ADDR_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RDY  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wr_bank;
    logic                  r_gap;
    logic [ADDR_W:0]       r_wptr [NUM_CH];
    logic [DATA_W-1:0]     r_mem [2**MEM_AW];
    logic                  r_ovf_flag;
    logic [OVF_CNT_W-1:0]  r_ovf_cnt;

    logic [DATA_W-1:0]     r_rd_data [RD_DELAY];
    logic                  r_rd_vld  [RD_DELAY];
    logic [ADDR_W-1:0]     r_rd_addr [RD_DELAY];
    logic [CH_W-1:0]       r_rd_ch   [RD_DELAY];

    logic                  w_ch_ok;
    logic [ADDR_W:0]       w_cur_wptr;
    logic                  w_drop;
    logic                  w_wr_acc;
    logic [NUM_CH-1:0]     w_full_nxt;
    logic                  w_fill_done;
    logic                  w_rd_done;
    logic                  w_rd_acc;
    logic                  w_swap;
    logic                  w_gap_nxt;

    // Write acceptance and look-ahead completion (includes this cycle's write)
    always_comb begin
        w_ch_ok    = ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));
        w_cur_wptr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ({1'b0, wr_ch} == (CH_W+1)'(c)) begin
                w_cur_wptr = r_wptr[c];
            end
        end
        // A full channel also covers "bank complete, swap pending"
        w_drop   = wr_valid && (!w_ch_ok || w_cur_wptr[ADDR_W]);
        w_wr_acc = wr_valid && !w_drop;
        for (int c = 0; c < NUM_CH; c++) begin
            w_full_nxt[c] = r_wptr[c][ADDR_W] ||
                            (w_wr_acc && ({1'b0, wr_ch} == (CH_W+1)'(c)) &&
                             (r_wptr[c] == (ADDR_W+1)'(DEPTH-1)));
        end
        w_fill_done = &w_full_nxt;
    end

    // Reader handshake FSM: next state, swap request and ready output
    always_comb begin
        w_state_nxt  = r_state;
        w_swap       = 1'b0;
        w_gap_nxt    = 1'b0;
        pcm_data_rdy = (r_state == S_RDY) && !r_gap;
        w_rd_done    = pcm_rd_done && pcm_data_rdy;
        w_rd_acc     = pcm_rden && pcm_data_rdy;
        case (r_state)
            S_IDLE: begin
                if (w_fill_done) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_RDY;
                end
            end
            S_RDY: begin
                if (w_rd_done) begin
                    if (w_fill_done) begin
                        // Hand over the next frame; ready drops for one cycle
                        w_swap    = 1'b1;
                        w_gap_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bank select, ready gap and per-channel write pointers
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            r_wr_bank <= 1'b0;
            r_gap     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c] <= '0;
            end
        end else begin
            r_gap <= w_gap_nxt;
            if (w_swap) begin
                r_wr_bank <= ~r_wr_bank;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_wptr[c] <= '0;
                end
            end else if (w_wr_acc) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if ({1'b0, wr_ch} == (CH_W+1)'(c)) begin
                        r_wptr[c] <= r_wptr[c] + (ADDR_W+1)'(1);
                    end
                end
            end
        end
    end

    // Sample RAM write into the fill bank (contents are not reset)
    always_ff @(posedge clk_ir) begin
        if (w_wr_acc) begin
            r_mem[{r_wr_bank, wr_ch, w_cur_wptr[ADDR_W-1:0]}] <= wr_data;
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            r_ovf_flag <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (w_drop) begin
            r_ovf_flag <= 1'b1;
            if (clr_ovf) begin
                r_ovf_cnt <= OVF_CNT_W'(1);
            end else if (!(&r_ovf_cnt)) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
            end
        end else if (clr_ovf) begin
            r_ovf_flag <= 1'b0;
            r_ovf_cnt  <= '0;
        end
    end

    // Read pipeline: RAM lookup from the issue-cycle read bank, then delay stages
    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            for (int k = 0; k < RD_DELAY; k++) begin
                r_rd_data[k] <= '0;
                r_rd_vld[k]  <= 1'b0;
                r_rd_addr[k] <= '0;
                r_rd_ch[k]   <= '0;
            end
        end else begin
            r_rd_data[0] <= r_mem[{~r_wr_bank, pcm_ch, pcm_addr}];
            r_rd_vld[0]  <= w_rd_acc;
            r_rd_addr[0] <= pcm_addr;
            r_rd_ch[0]   <= pcm_ch;
            for (int k = 1; k < RD_DELAY; k++) begin
                r_rd_data[k] <= r_rd_data[k-1];
                r_rd_vld[k]  <= r_rd_vld[k-1];
                r_rd_addr[k] <= r_rd_addr[k-1];
                r_rd_ch[k]   <= r_rd_ch[k-1];
            end
        end
    end

    assign pcm_rdata    = r_rd_vld[RD_DELAY-1] ? r_rd_data[RD_DELAY-1] : '0;
    assign pcm_rd_valid = r_rd_vld[RD_DELAY-1];
    assign pcm_raddr    = r_rd_addr[RD_DELAY-1];
    assign pcm_rch      = r_rd_ch[RD_DELAY-1];
    assign ovf_flag     = r_ovf_flag;
    assign ovf_cnt      = r_ovf_cnt;

endmodule
